// File: rtl/stream_demux_n.sv
// 1-to-N_CH valid/ready stream demultiplexer with a single registered output stage and per-packet channel lock.
// Optional discarded-beat counter port drop_cnt when STREAM_DEMUX_DROP_CNT_EN is defined.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  localparam int             N_SLOT = 1 << SEL_W;
  localparam logic [SEL_W:0] N_CH_W = (SEL_W + 1)'(N_CH);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    lock_q, lock_d;
  logic                full_q, full_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic [SEL_W-1:0]    chan_q, chan_d;

  logic [N_SLOT-1:0]   ready_pad;
  logic [N_SLOT-1:0]   valid_pad;
  logic [SEL_W-1:0]    eff_chan;
  logic                chan_ok;
  logic                accept;
  logic                drain;

  // Pad per-channel vectors to the full select range so chan_q always indexes in range.
  always_comb begin
    ready_pad               = '0;
    ready_pad[N_CH-1:0]     = out_ready;
    valid_pad               = '0;
    valid_pad[chan_q]       = full_q;
  end

  assign out_valid = valid_pad[N_CH-1:0];
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign busy      = (state_q == LOCK);

  assign drain    = full_q && ready_pad[chan_q];
  assign in_ready = !full_q || ready_pad[chan_q];
  assign accept   = in_valid && in_ready;
  assign eff_chan = (state_q == LOCK) ? lock_q : in_sel;
  assign chan_ok  = ({1'b0, eff_chan} < N_CH_W);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    full_d  = full_q;
    data_d  = data_q;
    last_d  = last_q;
    chan_d  = chan_q;

    if (drain) begin
      full_d = 1'b0;
    end
    // A beat for a nonexistent channel is consumed but never loaded.
    if (accept && chan_ok) begin
      full_d = 1'b1;
      data_d = in_data;
      last_d = in_last;
      chan_d = eff_chan;
    end

    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d = LOCK;
            lock_d  = in_sel;
          end
        end
        LOCK: begin
          if (in_last) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lock_q  <= '0;
      full_q  <= 1'b0;
      // NOTE: the payload register is reset too, because out_data must read zero out of reset.
      data_q  <= '0;
      last_q  <= 1'b0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      full_q  <= full_d;
      data_q  <= data_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
    end
  end

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && !chan_ok && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: vector table on a 4-channel instance, hand sequences on a 3-channel one.
// Drop counter checks are compiled in when STREAM_DEMUX_DROP_CNT_EN is defined.
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-channel instance
  logic       a_in_valid, a_in_ready, a_in_last, a_out_last, a_busy;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_in_sel;
  logic [3:0] a_out_valid, a_out_ready;

  // 3-channel instance
  logic       b_in_valid, b_in_ready, b_in_last, b_out_last, b_busy;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_in_sel;
  logic [2:0] b_out_valid, b_out_ready;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [15:0] a_drop_cnt, b_drop_cnt;
`endif

  stream_demux_n #(.DATA_W(8), .N_CH(4), .SEL_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_sel(a_in_sel), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(a_drop_cnt)
`endif
  );

  stream_demux_n #(.DATA_W(8), .N_CH(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sel(b_in_sel), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
    , .drop_cnt(b_drop_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [7:0] exp_data;
    logic       exp_last;
    logic       exp_busy;
  } vec_t;

  localparam int N_VEC = 14;
  vec_t vecs [N_VEC];

  task automatic b_drive(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                         input logic last);
    b_in_valid = vld;
    b_in_sel   = sel;
    b_in_data  = data;
    b_in_last  = last;
  endtask

  initial begin
    //              vld   sel    data   last  ordy     rdy   ov       data   last  busy
    // single-beat routing to ch2, then drain
    vecs[0]  = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'b1111, 1'b1, 4'b0100, 8'hA5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0};
    // 3-beat packet locked to ch1 while sel changes to 3
    vecs[2]  = '{1'b1, 2'd1, 8'h11, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h11, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 8'h22, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h22, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 2'd3, 8'h33, 1'b1, 4'b1111, 1'b1, 4'b0010, 8'h33, 1'b1, 1'b0};
    // back-pressure on ch1 for 4 cycles; other channels ready but irrelevant
    vecs[5]  = '{1'b1, 2'd1, 8'h44, 1'b0, 4'b1111, 1'b1, 4'b0010, 8'h44, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 2'd0, 8'h55, 1'b0, 4'b1101, 1'b0, 4'b0010, 8'h44, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 8'h55, 1'b0, 4'b1101, 1'b0, 4'b0010, 8'h44, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 2'd0, 8'h55, 1'b0, 4'b1101, 1'b0, 4'b0010, 8'h44, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 2'd0, 8'h55, 1'b1, 4'b1101, 1'b0, 4'b0010, 8'h44, 1'b0, 1'b1};
    // release: drain 44 and accept 55 on the same edge
    vecs[10] = '{1'b1, 2'd0, 8'h55, 1'b1, 4'b1111, 1'b1, 4'b0010, 8'h55, 1'b1, 1'b0};
    // channel switch at packet boundary: ch0 then ch3 on consecutive cycles
    vecs[11] = '{1'b1, 2'd0, 8'h66, 1'b1, 4'b1111, 1'b1, 4'b0001, 8'h66, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 2'd3, 8'h77, 1'b1, 4'b1111, 1'b1, 4'b1000, 8'h77, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'b1111, 1'b1, 4'b0000, 8'h00, 1'b0, 1'b0};

    // Reset held 3 cycles with random inputs
    rst_n = 1'b0;
    b_drive(1'b0, 2'd0, 8'h00, 1'b0);
    b_out_ready = 3'b111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_in_valid  = 1'($urandom);
      a_in_sel    = 2'($urandom);
      a_in_data   = 8'($urandom);
      a_in_last   = 1'($urandom);
      a_out_ready = 4'($urandom);
      #1;
      check($sformatf("rst%0d out_valid", c), 32'(a_out_valid), 32'd0);
      check($sformatf("rst%0d busy", c), 32'(a_busy), 32'd0);
      check($sformatf("rst%0d in_ready", c), 32'(a_in_ready), 32'd1);
    end
    check("rst out_data", 32'(a_out_data), 32'd0);
    check("rst out_last", 32'(a_out_last), 32'd0);

    @(negedge clk);
    rst_n       = 1'b1;
    a_in_valid  = 1'b0;
    a_out_ready = 4'b1111;
    @(posedge clk); #1;
    check("post-rst out_valid", 32'(a_out_valid), 32'd0);
    check("post-rst busy", 32'(a_busy), 32'd0);
    check("post-rst in_ready", 32'(a_in_ready), 32'd1);

    // Vector table: drive at negedge, check in_ready before the edge, registered outputs after it
    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clk);
      a_in_valid  = vecs[i].vld;
      a_in_sel    = vecs[i].sel;
      a_in_data   = vecs[i].data;
      a_in_last   = vecs[i].last;
      a_out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d busy", i), 32'(a_busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_ov != 4'b0000) begin
        check($sformatf("v%0d out_data", i), 32'(a_out_data), 32'(vecs[i].exp_data));
        check($sformatf("v%0d out_last", i), 32'(a_out_last), 32'(vecs[i].exp_last));
      end
    end

    // 3-channel instance: invalid select packet is consumed and dropped
    @(negedge clk);
    b_drive(1'b1, 2'd3, 8'hAA, 1'b0);
    #1;
    check("bad beat1 in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    check("bad beat1 out_valid", 32'(b_out_valid), 32'd0);
    check("bad beat1 busy", 32'(b_busy), 32'd1);

    @(negedge clk);
    b_drive(1'b1, 2'd0, 8'hBB, 1'b1);
    #1;
    check("bad beat2 in_ready", 32'(b_in_ready), 32'd1);
    @(posedge clk); #1;
    check("bad beat2 out_valid", 32'(b_out_valid), 32'd0);
    check("bad beat2 busy", 32'(b_busy), 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_cnt after bad packet", 32'(b_drop_cnt), 32'd2);
`endif

    // A valid single-beat packet afterwards routes normally
    @(negedge clk);
    b_drive(1'b1, 2'd0, 8'hCC, 1'b1);
    @(posedge clk); #1;
    check("b good out_valid", 32'(b_out_valid), 32'b001);
    check("b good out_data", 32'(b_out_data), 32'hCC);

    // Start another bad packet, then reset in the middle of it
    @(negedge clk);
    b_drive(1'b1, 2'd3, 8'hDD, 1'b0);
    @(posedge clk); #1;
    check("b bad2 busy", 32'(b_busy), 32'd1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("drop_cnt before reset", 32'(b_drop_cnt), 32'd3);
`endif
    b_drive(1'b0, 2'd0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-pkt rst busy", 32'(b_busy), 32'd0);
    check("mid-pkt rst out_valid", 32'(b_out_valid), 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
    check("mid-pkt rst drop_cnt", 32'(b_drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Lock was lost: the next beat takes its channel from in_sel
    @(negedge clk);
    b_drive(1'b1, 2'd1, 8'hEE, 1'b1);
    @(posedge clk); #1;
    check("post-rst b out_valid", 32'(b_out_valid), 32'b010);
    check("post-rst b out_data", 32'(b_out_data), 32'hEE);
    check("post-rst b busy", 32'(b_busy), 32'd0);

    @(negedge clk);
    b_drive(1'b0, 2'd0, 8'h00, 1'b0);
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
